serdesphy_pll_lock_controller: RTL
==================================

Name: serdesphy_pll_lock_controller

Overview:
Sequences the PLL phase frequency detector: enables it, lets the loop settle, then measures UP/DOWN pulse balance over fixed windows. It steps a coarse VCO band select toward balance and declares lock after consecutive balanced windows. It sits between PHY control (start/status) and the PFD/VCO, clocked by clk_feedback.

Parameters:
SETTLE_CYCLES, 256, cycles in SETTLE after enable or band change (>=2)
WINDOW_LOG2, 6, measurement window = 2^WINDOW_LOG2 cycles
LOCK_THRESH, 4, max |up_cnt - dn_cnt| for a window to count as balanced
LOCK_COUNT, 4, consecutive balanced windows required to assert locked
BAND_W, 4, width of VCO coarse band select

Ports:
clk_feedback  input  1  controller clock (PLL feedback clock)
rst_n  input  1  asynchronous active-low reset
start  input  1  level request: 1 = run calibration/lock, 0 = return to IDLE
up_pulse  input  1  PFD UP pulse
down_pulse  input  1  PFD DOWN pulse
pfd_enable  output  1  enable to PFD
band_sel  output  BAND_W  VCO coarse band select
locked  output  1  lock indication
cal_error  output  1  band range exhausted
state  output  3  current FSM state code (debug)

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk_feedback): state=IDLE, pfd_enable=0, band_sel=2^(BAND_W-1) (mid, 8 at default), locked=0, cal_error=0, all counters 0. Reset mid-operation returns immediately to these values.
- up_pulse/down_pulse pass through a 2-flop synchronizer each; a sample counts when the synchronized bit is 1 (2-cycle latency). Both high in one cycle: both counters increment.
- up_cnt/dn_cnt are WINDOW_LOG2+1 bits wide, so they cannot overflow within a window. Both clear at every window start.
- State codes: IDLE=0, SETTLE=1, MEASURE=2, ADJUST=3, LOCKED=4, FAIL=5.
- Any state with start=0: next cycle goes to IDLE, pfd_enable=0, locked=0, cal_error=0, band_sel=mid. This has priority over all other transitions.
- IDLE: on start=1, go to SETTLE and clear the settle counter.
- SETTLE: pfd_enable=1. Count exactly SETTLE_CYCLES cycles, then go to MEASURE. Counts are ignored here.
- MEASURE: pfd_enable=1. Accumulate for 2^WINDOW_LOG2 cycles. At window end, evaluate diff = up_cnt - dn_cnt (signed, WINDOW_LOG2+2 bits):
  - |diff| <= LOCK_THRESH: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED (locked=1 on the first LOCKED cycle). Otherwise start a new window.
  - |diff| > LOCK_THRESH: good_cnt=0, go to ADJUST.
- ADJUST (one cycle):
  - diff>0 (feedback slow): band_sel+1.
  - diff<0: band_sel-1.
  - On success, go to SETTLE.
  - If band_sel=2^BAND_W-1 with diff>0, or band_sel=0 with diff<0: no change, go to FAIL.
- LOCKED: locked=1. Windows keep running. One unbalanced window sets a miss flag; a balanced window clears it. Two consecutive unbalanced windows: locked=0, good_cnt=0, go to MEASURE with band unchanged.
- FAIL: cal_error=1, pfd_enable=0, band_sel held. Exit only via start=0.
- Outputs are registered. band_sel changes only in ADJUST or on return to IDLE.

Test Plan:
Use SETTLE_CYCLES=16, WINDOW_LOG2=4, LOCK_THRESH=2, LOCK_COUNT=2 unless stated.
- Reset/idle: assert rst_n=0 mid-MEASURE -> pfd_enable=0, band_sel=8, locked=0, cal_error=0, state=0 immediately.
- Quick lock: start=1, no pulses -> state=1 for 16 cycles; 2 balanced 16-cycle windows; locked=1 at cycle ~1+16+32; band_sel=8.
- Band up: drive up_pulse high continuously for the first window -> ADJUST, band_sel=9, re-SETTLE. Then drive balanced alternating UP/DOWN -> lock with band_sel=9.
- Saturation fail: up_pulse held high forever -> band_sel steps 9..15, then FAIL, cal_error=1, pfd_enable=0. Drop start -> IDLE, band_sel=8, cal_error=0.
- Lock loss: in LOCKED, one window of 5 extra DOWN pulses -> locked stays 1. Two consecutive such windows -> locked=0, state=2, band_sel unchanged.
- Simultaneous pulses: up_pulse=down_pulse=1 every cycle -> diff=0, lock achieved, band_sel=8.

Source files
------------

// File: rtl/serdesphy_pll_lock_controller.sv
// PLL lock controller: settles the PFD loop, measures UP/DOWN balance per window,
// steps the coarse VCO band toward balance and reports lock or range exhaustion.
module serdesphy_pll_lock_controller #(
    parameter int SETTLE_CYCLES = 256,
    parameter int WINDOW_LOG2   = 6,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_COUNT    = 4,
    parameter int BAND_W        = 4
) (
    input  logic              clk_feedback,
    input  logic              rst_n,
    input  logic              start,
    input  logic              up_pulse,
    input  logic              down_pulse,
    output logic              pfd_enable,
    output logic [BAND_W-1:0] band_sel,
    output logic              locked,
    output logic              cal_error,
    output logic [2:0]        state
);

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = WINDOW_LOG2 + 1;
    localparam int DW = WINDOW_LOG2 + 2;
    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0]     THR         = DW'(LOCK_THRESH);
    localparam logic [GW-1:0]     GOOD_LAST   = GW'(LOCK_COUNT - 1);
    localparam logic [BAND_W-1:0] BAND_MID    = {1'b1, {(BAND_W-1){1'b0}}};
    localparam logic [BAND_W-1:0] BAND_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_ADJUST  = 3'd3,
        S_LOCKED  = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             up_s_q, dn_s_q;
    logic [SW-1:0]          settle_q, settle_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [CW-1:0]          up_q, up_d, dn_q, dn_d;
    logic [GW-1:0]          good_q, good_d;
    logic                   miss_q, miss_d;
    logic                   dpos_q, dpos_d;
    logic [BAND_W-1:0]      band_q, band_d;
    logic                   pfd_q, pfd_d;
    logic                   locked_q, locked_d;
    logic                   calerr_q, calerr_d;

    logic [CW-1:0]        up_nx, dn_nx;
    logic signed [DW-1:0] diff;
    logic [DW-1:0]        mag;
    logic                 bal;
    logic                 win_end;

    always_comb begin
        up_nx   = up_q + CW'(up_s_q[1]);
        dn_nx   = dn_q + CW'(dn_s_q[1]);
        diff    = $signed({1'b0, up_nx}) - $signed({1'b0, dn_nx});
        mag     = diff[DW-1] ? DW'(-diff) : DW'(diff);
        bal     = (mag <= THR);
        win_end = &win_q;
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        up_d     = up_q;
        dn_d     = dn_q;
        good_d   = good_q;
        miss_d   = miss_q;
        dpos_d   = dpos_q;
        band_d   = band_q;
        if (!start) begin
            state_d  = S_IDLE;
            settle_d = '0;
            win_d    = '0;
            up_d     = '0;
            dn_d     = '0;
            good_d   = '0;
            miss_d   = 1'b0;
            band_d   = BAND_MID;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = S_MEASURE;
                        win_d   = '0;
                        up_d    = '0;
                        dn_d    = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_MEASURE, S_LOCKED: begin
                    win_d = win_q + 1'b1;
                    up_d  = up_nx;
                    dn_d  = dn_nx;
                    if (win_end) begin
                        up_d = '0;
                        dn_d = '0;
                        if (state_q == S_MEASURE) begin
                            if (bal) begin
                                good_d = good_q + 1'b1;
                                if (good_q == GOOD_LAST) begin
                                    state_d = S_LOCKED;
                                    miss_d  = 1'b0;
                                end
                            end else begin
                                good_d  = '0;
                                dpos_d  = ~diff[DW-1];
                                state_d = S_ADJUST;
                            end
                        end else if (bal) begin
                            miss_d = 1'b0;
                        end else if (miss_q) begin
                            // second miss in a row: lock lost, keep band
                            state_d = S_MEASURE;
                            good_d  = '0;
                            miss_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
                S_ADJUST: begin
                    settle_d = '0;
                    if (dpos_q) begin
                        if (band_q == BAND_MAX) state_d = S_FAIL;
                        else begin
                            band_d  = band_q + 1'b1;
                            state_d = S_SETTLE;
                        end
                    end else begin
                        if (band_q == '0) state_d = S_FAIL;
                        else begin
                            band_d  = band_q - 1'b1;
                            state_d = S_SETTLE;
                        end
                    end
                end
                S_FAIL: state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
        end
        pfd_d    = (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                   (state_d == S_ADJUST) || (state_d == S_LOCKED);
        locked_d = (state_d == S_LOCKED);
        calerr_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk_feedback or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            up_s_q   <= '0;
            dn_s_q   <= '0;
            settle_q <= '0;
            win_q    <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            good_q   <= '0;
            miss_q   <= 1'b0;
            dpos_q   <= 1'b0;
            band_q   <= BAND_MID;
            pfd_q    <= 1'b0;
            locked_q <= 1'b0;
            calerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            up_s_q   <= {up_s_q[0], up_pulse};
            dn_s_q   <= {dn_s_q[0], down_pulse};
            settle_q <= settle_d;
            win_q    <= win_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            dpos_q   <= dpos_d;
            band_q   <= band_d;
            pfd_q    <= pfd_d;
            locked_q <= locked_d;
            calerr_q <= calerr_d;
        end
    end

    assign pfd_enable = pfd_q;
    assign band_sel   = band_q;
    assign locked     = locked_q;
    assign cal_error  = calerr_q;
    assign state      = state_q;

endmodule
